// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution window feeder.
package conv_pkg;

  localparam int DATA_W = 4;
  localparam int TAPS   = 9;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic [3:0]               elem_t;

  localparam elem_t FRAME_LAST = elem_t'(TAPS - 1);

endpackage

// File: rtl/conv_patch_bank.sv
// One 9-entry patch register bank: pixels append at the current count,
// clear empties it, and any entry can be read by index.
module conv_patch_bank #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int TAPS   = conv_pkg::TAPS
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                clr,
  input  logic                we,
  input  logic [DATA_W-1:0]   wdata,
  input  conv_pkg::elem_t     rd_idx,
  output logic [DATA_W-1:0]   rd_data,
  output conv_pkg::elem_t     count
);

  localparam conv_pkg::elem_t FULL_CNT = conv_pkg::elem_t'(TAPS);

  logic [DATA_W-1:0] mem_r [TAPS];
  conv_pkg::elem_t   count_r;

  // Fill count; clear takes priority over an append
  always_ff @(posedge clk) begin
    if (rstb) begin
      count_r <= 4'd0;
    end else if (clr) begin
      count_r <= 4'd0;
    end else if (we && (count_r < FULL_CNT)) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Pixel storage; contents are only consumed behind a full count, so no reset
  always_ff @(posedge clk) begin
    if (we && !clr && (count_r < FULL_CNT)) begin
      mem_r[count_r] <= wdata;
    end
  end

  // Read port
  always_comb begin
    if (rd_idx < FULL_CNT) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/conv_window_feeder.sv
// Feeds the 3x3 MAC one (pixel, weight) pair per clock in fixed 9-cycle
// frames, using ping-pong patch banks and commit-at-boundary weights.
module conv_window_feeder #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int TAPS   = conv_pkg::TAPS
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              w_we,
  input  logic [3:0]        w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_commit,
  output logic [DATA_W-1:0] IN,
  output logic [DATA_W-1:0] W,
  output logic              frame_start,
  output logic              frame_valid
);

  localparam conv_pkg::elem_t FULL_CNT = conv_pkg::elem_t'(TAPS);

  conv_pkg::elem_t   elem_r;
  logic              sel_r;
  logic              commit_pend_r;
  logic [DATA_W-1:0] staging_r     [TAPS];
  logic [DATA_W-1:0] active_r      [TAPS];
  logic [DATA_W-1:0] staging_nxt_s [TAPS];

  conv_pkg::elem_t   cnt0_s, cnt1_s, fill_cnt_s, drain_cnt_s;
  logic [DATA_W-1:0] rd0_s, rd1_s, drain_rd_s;
  logic              accept_s, boundary_s, swap_s, apply_s, drain_full_s;

  // sel_r = 0: bank0 fills while bank1 drains
  assign fill_cnt_s   = sel_r ? cnt1_s : cnt0_s;
  assign drain_cnt_s  = sel_r ? cnt0_s : cnt1_s;
  assign drain_rd_s   = sel_r ? rd0_s  : rd1_s;
  assign pix_ready    = (fill_cnt_s < FULL_CNT);
  assign accept_s     = pix_valid && pix_ready;
  assign boundary_s   = (elem_r == conv_pkg::FRAME_LAST);
  assign swap_s       = (fill_cnt_s == FULL_CNT) ||
                        (accept_s && (fill_cnt_s == (FULL_CNT - 4'd1)));
  assign apply_s      = boundary_s && (commit_pend_r || w_commit);
  assign drain_full_s = (drain_cnt_s == FULL_CNT);

  // The drain bank is released at every boundary, swapped or not
  conv_patch_bank #(.DATA_W(DATA_W), .TAPS(TAPS)) u_bank0 (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (boundary_s && sel_r),
    .we      (accept_s && !sel_r),
    .wdata   (pix_data),
    .rd_idx  (elem_r),
    .rd_data (rd0_s),
    .count   (cnt0_s)
  );

  conv_patch_bank #(.DATA_W(DATA_W), .TAPS(TAPS)) u_bank1 (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (boundary_s && !sel_r),
    .we      (accept_s && sel_r),
    .wdata   (pix_data),
    .rd_idx  (elem_r),
    .rd_data (rd1_s),
    .count   (cnt1_s)
  );

  // Staging next-state; out-of-range addresses match no entry
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      staging_nxt_s[i] = (w_we && (w_addr == 4'(i))) ? w_data : staging_r[i];
    end
  end

  // Element counter, bank select and commit bookkeeping
  always_ff @(posedge clk) begin
    if (rstb) begin
      elem_r        <= 4'd0;
      sel_r         <= 1'b0;
      commit_pend_r <= 1'b0;
    end else begin
      elem_r <= boundary_s ? 4'd0 : elem_r + 4'd1;
      if (boundary_s && swap_s) begin
        sel_r <= ~sel_r;
      end
      if (apply_s) begin
        commit_pend_r <= 1'b0;
      end else if (w_commit) begin
        commit_pend_r <= 1'b1;
      end
    end
  end

  // Weight registers; active only changes on a frame boundary
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < TAPS; i++) begin
        staging_r[i] <= {DATA_W{1'b0}};
        active_r[i]  <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        staging_r[i] <= staging_nxt_s[i];
        if (apply_s) begin
          active_r[i] <= staging_nxt_s[i];
        end
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    if (drain_full_s) begin
      IN = drain_rd_s;
      W  = active_r[elem_r];
    end else begin
      IN = {DATA_W{1'b0}};
      W  = {DATA_W{1'b0}};
    end
  end

  assign frame_start = (elem_r == 4'd0);
  assign frame_valid = drain_full_s;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: expected per-cycle outputs are queued ahead of stimulus and
// a negedge monitor compares them against the feeder outputs.
module tb_conv_window_feeder;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       pix_valid = 1'b0, w_we = 1'b0, w_commit = 1'b0;
  logic [3:0] pix_data = 4'd0, w_addr = 4'd0, w_data = 4'd0;
  logic       pix_ready, frame_start, frame_valid;
  logic [3:0] IN, W;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  typedef struct {
    int         cyc;
    logic [9:0] exp;
  } exp_t;
  exp_t sb_q[$];

  logic [8:0][3:0] w1, w2, w3, wz, p1, p7, pa, pb, pc, pd, pe, pf, p4;
  logic [3:0] ramp;

  always #5 clk = ~clk;

  conv_window_feeder dut (
    .clk         (clk),
    .rstb        (rstb),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_commit    (w_commit),
    .IN          (IN),
    .W           (W),
    .frame_start (frame_start),
    .frame_valid (frame_valid)
  );

  // Cycle index since reset release; element = tcyc % 9
  always @(posedge clk) tcyc <= rstb ? 0 : tcyc + 1;

  task automatic check(input string name, input int cyc,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push_frame(input int f, input bit v, input logic [8:0][3:0] p,
                            input logic [8:0][3:0] w, input int n);
    exp_t x;
    for (int e = 0; e < n; e++) begin
      x.cyc = 9 * f + e;
      x.exp = {(e == 0), v, (v ? p[e] : 4'd0), (v ? w[e] : 4'd0)};
      sb_q.push_back(x);
    end
  endtask

  task automatic drive(input bit pv, input logic [3:0] pd_v, input bit we,
                       input logic [3:0] wa, input logic [3:0] wd, input bit wc);
    pix_valid = pv; pix_data = pd_v; w_we = we; w_addr = wa; w_data = wd; w_commit = wc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  // Monitor: {frame_start, frame_valid, IN, W} vs the queued expectation
  always @(negedge clk) begin
    if (!rstb && sb_q.size() > 0) begin
      if (sb_q[0].cyc == tcyc) begin
        check("out", tcyc, {6'd0, frame_start, frame_valid, IN, W}, {6'd0, sb_q[0].exp});
        void'(sb_q.pop_front());
      end else if (sb_q[0].cyc < tcyc) begin
        check("missed", sb_q[0].cyc, 16'(tcyc), 16'(sb_q[0].cyc));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int e = 0; e < 9; e++) begin
      w1[e] = 4'd1;
      w2[e] = 4'(-((e % 8) + 1));
      wz[e] = 4'd0;
      p1[e] = 4'(e + 1);
      p7[e] = 4'd7;
      pa[e] = 4'(e);
      pb[e] = 4'(9 + e);
      pc[e] = 4'(18 + e);
      pd[e] = 4'(e + 1);
      pe[e] = 4'(7 - e);
      pf[e] = 4'd2;
      p4[e] = 4'd4;
    end
    w3 = w2; w3[0] = 4'd5;
    pd[7] = 4'h8; pd[8] = 4'hD;

    repeat (3) @(posedge clk);
    #1;
    check("reset", tcyc, {11'd0, frame_start, frame_valid, pix_ready, IN, W},
          {11'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0});

    push_frame(0, 1'b0, wz, wz, 9);
    push_frame(1, 1'b1, p1, w1, 9);
    push_frame(2, 1'b1, p7, w2, 9);
    push_frame(3, 1'b0, wz, wz, 9);
    push_frame(4, 1'b0, wz, wz, 9);
    push_frame(5, 1'b1, pa, w2, 9);
    push_frame(6, 1'b1, pb, w2, 9);
    push_frame(7, 1'b1, pc, w2, 9);
    push_frame(8, 1'b0, wz, wz, 9);
    push_frame(9, 1'b1, pd, w2, 9);
    push_frame(10, 1'b0, wz, wz, 9);
    push_frame(11, 1'b1, pe, w2, 9);
    push_frame(12, 1'b1, pf, w3, 9);
    push_frame(13, 1'b0, wz, wz, 5);
    rstb = 1'b0;

    // Frame 0: weights all +1 committed on the boundary edge, pixels 1..9
    for (int e = 0; e < 9; e++) drive(1'b1, 4'(e + 1), 1'b1, 4'(e), 4'd1, (e == 8));
    // Frame 1: staging -1..-8,-1 with a mid-frame commit, pixels all 7
    for (int e = 0; e < 9; e++) drive(1'b1, 4'd7, 1'b1, 4'(e), w2[e], (e == 1));
    idle(13);
    // Cycles 31..62: pix_valid held high with ramp data
    ramp = 4'd0;
    for (int c = 31; c <= 62; c++) begin
      check("pix_ready", c, {15'd0, pix_ready}, {15'd0, !((c >= 40) && (c <= 44))});
      drive(1'b1, ramp, 1'b0, 4'd0, 4'd0, 1'b0);
      if (!((c >= 40) && (c <= 44))) ramp = ramp + 4'd1;
    end
    idle(9);
    // Frame 8: ninth pixel lands on the boundary edge
    for (int e = 0; e < 9; e++) drive(1'b1, pd[e], 1'b0, 4'd0, 4'd0, 1'b0);
    // Frame 9: eight pixels, ninth arrives at element 0 of frame 10
    for (int e = 0; e < 8; e++) drive(1'b1, pe[e], 1'b0, 4'd0, 4'd0, 1'b0);
    idle(1);
    drive(1'b1, pe[8], 1'b0, 4'd0, 4'd0, 1'b0);
    idle(8);
    // Frame 11: staging[0]=5, ignored write to addr 12, commit at element 3
    for (int e = 0; e < 9; e++)
      drive(1'b1, 4'd2, (e < 2), ((e == 0) ? 4'd0 : 4'd12), ((e == 0) ? 4'd5 : 4'd3), (e == 3));
    idle(9);
    // Frame 13: 4 pixels and a pending commit, then reset at element 5
    for (int e = 0; e < 5; e++) drive((e < 4), 4'd6, (e == 1), 4'd1, 4'd2, (e == 2));
    rstb = 1'b1;
    idle(1);
    check("reset_mid", tcyc, {11'd0, frame_start, frame_valid, pix_ready, IN, W},
          {11'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0});
    idle(1);
    check("sb_pre_reset", 0, 16'(sb_q.size()), 16'd0);
    push_frame(0, 1'b0, wz, wz, 9);
    push_frame(1, 1'b1, p4, wz, 9);
    push_frame(2, 1'b0, wz, wz, 9);
    rstb = 1'b0;
    check("ready_after_rst", tcyc, {15'd0, pix_ready}, 16'd1);
    for (int e = 0; e < 9; e++) drive(1'b1, 4'd4, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(18);
    for (int k = 0; (k < 20) && (sb_q.size() > 0); k++) idle(1);
    check("sb_empty", tcyc, 16'(sb_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
